// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM encoding, bus widths and
// the captured-request record.
// No logic; imported by the interface, the RAM and the top.
package mem_responder_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Request fields frozen at acceptance so later bus changes are ignored.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> responder bus: request/rw/addr/data out, q/ack/busy back.
// No latency of its own; pure wiring bundle.
// No backpressure; the initiator watches m_busy and m_ack.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              m_req;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_q;
  logic              m_ack;
  logic              m_busy;

  modport master (
    output m_req, m_rw, m_addr, m_data,
    input  m_q, m_ack, m_busy
  );

  modport slave (
    input  m_req, m_rw, m_addr, m_data,
    output m_q, m_ack, m_busy
  );

endinterface

// File: rtl/mem_responder_ram.sv
// 4096x16 storage: synchronous write port, registered read port.
// Latency: write lands and read data appears one edge after we/re.
// No backpressure; rd_dat holds its value until the next re.
// Ports: clk, rst_n (clears only the read register), we, re, addr, wr_dat, rd_dat.
module ram_4096x16
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_dat_q, rd_dat_d;

  // The array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_dat;
    end
  end

  // Read register only updates on a read, so it holds across writes/idle.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (re) begin
      rd_dat_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one access in IDLE, waits, then acks.
// Latency: m_ack in the cycle after edge E(WAIT_STATES+1) from acceptance at E0.
// No backpressure; m_req is ignored outside IDLE (spacing WAIT_STATES+3 cycles).
// Ports: clock, reset (async active-low), bus (slave side of mem_responder_if).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 4096
) (
  input  logic     clock,
  input  logic     reset,
  mem_responder_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              cap_q, cap_d;
  logic              access_vld;
  logic [DATA_W-1:0] rd_dat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    access_vld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_req) begin
          cap_d.rw   = bus.m_rw;
          cap_d.addr = bus.m_addr;
          cap_d.data = bus.m_data;
          cnt_d      = WAIT_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The RAM performs the access on the same edge that enters ACK,
          // so read data is already registered when m_ack is high.
          access_vld = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Async reset drops state_q to IDLE immediately, which also kills
  // access_vld, so an aborted write never reaches the array.
  ram_4096x16 #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clock),
    .rst_n  (reset),
    .we     (access_vld & cap_q.rw),
    .re     (access_vld & ~cap_q.rw),
    .addr   (cap_q.addr),
    .wr_dat (cap_q.data),
    .rd_dat (rd_dat)
  );

  assign bus.m_q    = rd_dat;
  assign bus.m_ack  = (state_q == ST_ACK);
  assign bus.m_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table-driven accesses with a scoreboard on a
// WAIT_STATES=1 instance, plus hand sequences on WAIT_STATES=0 and =3 instances.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int W1 = 1;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] exp_q;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t vecs[13];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_responder_if if1 ();
  mem_responder_if if0 ();
  mem_responder_if if3 ();

  mem_responder #(.WAIT_STATES(W1), .DEPTH(4096)) dut1 (.clock(clock), .reset(reset), .bus(if1));
  mem_responder #(.WAIT_STATES(0),  .DEPTH(4096)) dut0 (.clock(clock), .reset(reset), .bus(if0));
  mem_responder #(.WAIT_STATES(3),  .DEPTH(4096)) dut3 (.clock(clock), .reset(reset), .bus(if3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the falling edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Scoreboard consumer for the W=1 instance: every ack must match the
  // oldest outstanding expectation in both data and cycle.
  always @(negedge clock) begin
    if (if1.m_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'(if1.m_ack), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ack_q", 32'(if1.m_q), 32'(e.q));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic acc1(input vec_t v);
    exp_t e;
    if1.m_req  = 1'b1;
    if1.m_rw   = v.rw;
    if1.m_addr = v.addr;
    if1.m_data = v.data;
    e.q   = v.exp_q;
    e.cyc = cyc + W1 + 2;
    sbq.push_back(e);
    step();
    // Disturb every request field after acceptance.
    if1.m_req  = 1'b0;
    if1.m_rw   = ~v.rw;
    if1.m_addr = v.addr ^ 12'h030;
    if1.m_data = ~v.data;
    chk("busy_after_accept", 32'(if1.m_busy), 32'd1);
    for (int i = 0; i < 12 && sbq.size() != 0; i++) step();
    if (sbq.size() != 0) begin
      chk("ack_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    step();
    chk("busy_back_idle", 32'(if1.m_busy), 32'd0);
  endtask

  task automatic acc3(input logic rw, input logic [11:0] addr, input logic [15:0] data,
                      output int lat, output logic [15:0] q);
    lat = -1;
    q   = 16'hxxxx;
    if3.m_req  = 1'b1;
    if3.m_rw   = rw;
    if3.m_addr = addr;
    if3.m_data = data;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) begin
        if3.m_req  = 1'b0;
        if3.m_rw   = ~rw;
        if3.m_addr = ~addr;
        if3.m_data = ~data;
      end
      if (if3.m_ack === 1'b1) begin
        lat = i;
        q   = if3.m_q;
        break;
      end
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals0[3];
    logic [15:0] q3;
    int          lat3;
    int          ack3_seen;
    vec_t        v;

    vecs[0]  = '{1'b1, 12'h005, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 12'h005, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 12'h000, 16'h1234, 16'hBEEF};
    vecs[3]  = '{1'b1, 12'hFFF, 16'h5678, 16'hBEEF};
    vecs[4]  = '{1'b0, 12'h000, 16'h0000, 16'h1234};
    vecs[5]  = '{1'b0, 12'hFFF, 16'h0000, 16'h5678};
    vecs[6]  = '{1'b1, 12'h010, 16'hCAFE, 16'h5678};
    vecs[7]  = '{1'b1, 12'h020, 16'h0BAD, 16'h5678};
    vecs[8]  = '{1'b0, 12'h010, 16'h0000, 16'hCAFE};
    vecs[9]  = '{1'b1, 12'h7A5, 16'h0001, 16'hCAFE};
    vecs[10] = '{1'b0, 12'h7A5, 16'h0000, 16'h0001};
    vecs[11] = '{1'b1, 12'h7A5, 16'hFFFF, 16'h0001};
    vecs[12] = '{1'b0, 12'h7A5, 16'h0000, 16'hFFFF};
    vals0[0] = 16'h1111;
    vals0[1] = 16'h2222;
    vals0[2] = 16'h3333;

    reset = 1'b0;
    if1.m_req = 1'b0; if1.m_rw = 1'b0; if1.m_addr = '0; if1.m_data = '0;
    if0.m_req = 1'b0; if0.m_rw = 1'b0; if0.m_addr = '0; if0.m_data = '0;
    if3.m_req = 1'b0; if3.m_rw = 1'b0; if3.m_addr = '0; if3.m_data = '0;
    step();
    step();
    chk("rst_q", 32'(if1.m_q), 32'd0);
    chk("rst_ack", 32'(if1.m_ack), 32'd0);
    chk("rst_busy", 32'(if1.m_busy), 32'd0);
    chk("rst_busy3", 32'(if3.m_busy), 32'd0);

    // First request is presented together with reset release.
    reset = 1'b1;
    for (int k = 0; k < 13; k++) acc1(vecs[k]);

    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_busy", 32'(if1.m_busy), 32'd0);
      chk("idle_ack", 32'(if1.m_ack), 32'd0);
      chk("idle_q_hold", 32'(if1.m_q), 32'hFFFF);
    end

    // WAIT_STATES=0: preload, then stream reads with m_req held high.
    for (int k = 0; k < 3; k++) begin
      if0.m_req  = 1'b1;
      if0.m_rw   = 1'b1;
      if0.m_addr = 12'(k);
      if0.m_data = vals0[k];
      step();
      if0.m_req = 1'b0;
      step();
      step();
    end
    if0.m_req  = 1'b1;
    if0.m_rw   = 1'b0;
    if0.m_addr = 12'h000;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("w0_ack_pattern", 32'(if0.m_ack), 32'((i % 3) == 2));
      if ((i % 3) == 2) chk("w0_stream_q", 32'(if0.m_q), 32'(vals0[i / 3]));
      if (i < 8) if0.m_addr = 12'((i + 2) / 3);
      else       if0.m_req  = 1'b0;
    end
    step();
    chk("w0_end_busy", 32'(if0.m_busy), 32'd0);
    chk("w0_end_ack", 32'(if0.m_ack), 32'd0);

    // WAIT_STATES=3: normal write, aborted write, read back the old value.
    acc3(1'b1, 12'hFFF, 16'h5A5A, lat3, q3);
    chk("w3_write_latency", 32'(lat3), 32'd5);
    if3.m_req  = 1'b1;
    if3.m_rw   = 1'b1;
    if3.m_addr = 12'hFFF;
    if3.m_data = 16'hAAAA;
    step();
    if3.m_req = 1'b0;
    step();
    chk("w3_busy_in_wait", 32'(if3.m_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("w3_abort_busy", 32'(if3.m_busy), 32'd0);
    chk("w3_abort_ack", 32'(if3.m_ack), 32'd0);
    chk("w3_abort_q", 32'(if3.m_q), 32'd0);
    chk("w1_reset_q", 32'(if1.m_q), 32'd0);
    step();
    step();
    reset = 1'b1;
    ack3_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if3.m_ack === 1'b1) ack3_seen++;
    end
    chk("w3_no_ack_after_abort", 32'(ack3_seen), 32'd0);
    acc3(1'b0, 12'hFFF, 16'h0000, lat3, q3);
    chk("w3_read_latency", 32'(lat3), 32'd5);
    chk("w3_read_old_value", 32'(q3), 32'h5A5A);

    // Memory of the W=1 instance survives the reset pulse.
    v = '{1'b0, 12'h7A5, 16'h0000, 16'hFFFF};
    acc1(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
